frequency_measure_encoder: RTL and testbench
============================================

Name: frequency_measure_encoder

Overview:
Encoder-side counterpart of the frequency-domain inverse reconstruction block. It accepts one 8x8 block of 8-bit pixels as a raster-order stream and forms NUM_MEAS compressive measurements using the natural-order 64-point Walsh-Hadamard rows 0..NUM_MEAS-1. It then streams the 16-bit measurements out serially in the format the reconstruction side consumes (measurements0..47). It sits between the image block reader and the measurement channel/storage.

Parameters:
NUM_MEAS, 48, number of measurements per block (legal range 1..64; 48 = ratio 0.75, 32 = ratio 0.5)
OFFSET, 8192, unsigned bias added to every measurement with index k>=1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pixel_in  input  8  unsigned pixel, raster order, index i = 0..63
pixel_valid  input  1  pixel_in valid
pixel_ready  output  1  block accepts a pixel this cycle
meas_data  output  16  current measurement value
meas_index  output  6  index k of meas_data
meas_valid  output  1  meas_data/meas_index valid
meas_ready  input  1  downstream accepts the measurement
meas_last  output  1  high with meas_index == NUM_MEAS-1 while meas_valid
finish_flag  output  1  one-cycle pulse after the last measurement of a block is accepted

Behaviour:
- Sign function: s(k,i) = +1 if popcount(k AND i) is even, else -1 (k, i are 6-bit).
- acc[k] = sum over i = 0..63 of s(k,i)*pixel_i. acc is 17-bit signed; no overflow is possible.
- Output value for k=0: meas_data = acc[0], range 0..16320.
- Output value for k>=1: meas_data = acc[k] + OFFSET, truncated to 16 bits. With the default OFFSET the range is 32..16352.
- States:
  - ACCUM: pixel_ready=1, meas_valid=0.
  - OUTPUT: pixel_ready=0, meas_valid=1.
  - DONE: pixel_ready=0, meas_valid=0, finish_flag=1.
- Pixel handshake:
  - A pixel is accepted when pixel_valid & pixel_ready.
  - On acceptance, all NUM_MEAS accumulators update in the same cycle: acc[k] += s(k,pix_cnt)*pixel_in.
  - pix_cnt (6-bit) then increments.
- ACCUM->OUTPUT: occurs on the clock edge that accepts pixel 63. The next cycle shows meas_valid=1 and meas_index=0, so first-measurement latency after the last pixel is 1 cycle.
- Measurement handshake:
  - A measurement transfers when meas_valid & meas_ready; meas_index then increments.
  - While meas_valid=1 and meas_ready=0, meas_data, meas_index and meas_last hold stable.
- OUTPUT->DONE: on transfer of index NUM_MEAS-1.
- DONE (exactly 1 cycle): finish_flag=1, all accumulators and pix_cnt clear to 0, then return to ACCUM.
- A block therefore takes at least 64 + NUM_MEAS + 1 cycles with no stalls.
- pixel_valid is ignored outside ACCUM; the source must hold its pixel.
- Gaps in pixel_valid during ACCUM only pause accumulation; there is no timeout.
- Asynchronous reset (reset=0), at any time including mid-block:
  - state=ACCUM; pixel_ready=1; meas_valid=0; meas_last=0; finish_flag=0; meas_index=0; meas_data=0; pix_cnt=0; all acc=0.
  - A partial block is discarded with no output.
  - pixel_ready rises immediately with reset assertion and stays 1 through release.
- meas_data/meas_index are registered from the accumulator array. No combinational path runs from meas_ready or pixel_valid to any output.

Test Plan:
- Reset, then 64 pixels of 0 with no stalls -> meas0=0, meas1..47=8192; meas_last on index 47; finish_flag pulses 1 cycle after that transfer; pixel_ready=1 the following cycle.
- 64 pixels of 255 -> meas0=16320, meas1..47=8192 (each Hadamard row k>=1 sums to zero).
- pixel0=100, all others 0 -> meas0=100, meas1..47=8292. Then pixel63=10, all others 0 -> meas0=10, meas1=8182, meas3=8202, meas7=8182.
- Backpressure: hold meas_ready=0 for 5 cycles while meas_index=7 -> meas_data/meas_index unchanged; pixel_ready=0; no index skipped; 48 transfers total.
- Assert reset after 30 pixels, release, then send a full all-zero block -> no meas_valid before the new block completes; outputs match the all-zero results (no residue).
- NUM_MEAS=32, random pixels with random pixel_valid gaps -> exactly 32 measurements; values match the reference model; meas_last on index 31.

Source files
------------

// File: rtl/frequency_measure_encoder_if.sv
// Bundles the pixel-input and measurement-output handshakes of
// frequency_measure_encoder.
//   pixel_in/pixel_valid/pixel_ready          : raster-order pixel stream into the encoder
//   meas_data/meas_index/meas_valid/meas_ready : serial measurement stream out of the encoder
//   meas_last                                  : marks measurement NUM_MEAS-1
//   finish_flag                                : one-cycle end-of-block pulse
// master = block reader / measurement sink side, slave = encoder.
interface frequency_measure_encoder_if;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [15:0] meas_data;
  logic [5:0]  meas_index;
  logic        meas_valid;
  logic        meas_ready;
  logic        meas_last;
  logic        finish_flag;

  modport master (
    output pixel_in, pixel_valid, meas_ready,
    input  pixel_ready, meas_data, meas_index, meas_valid, meas_last, finish_flag
  );

  modport slave (
    input  pixel_in, pixel_valid, meas_ready,
    output pixel_ready, meas_data, meas_index, meas_valid, meas_last, finish_flag
  );
endinterface

// File: rtl/frequency_measure_encoder.sv
// Compressive measurement encoder for one 8x8 block of 8-bit pixels.
// Accumulates 64 raster-order pixels against natural-order Walsh-Hadamard rows
// 0..NUM_MEAS-1, then streams the measurements out one per handshake. Rows k>=1
// carry an unsigned OFFSET bias so every measurement fits an unsigned 16-bit word.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of frequency_measure_encoder_if (pixel in, measurements out)
module frequency_measure_encoder #(
  parameter int unsigned NUM_MEAS = 48,
  parameter int unsigned OFFSET   = 8192
) (
  input logic                         clk,
  input logic                         reset,
  frequency_measure_encoder_if.slave  bus
);

  typedef enum logic [1:0] {StAccum, StOutput, StDone} state_e;

  localparam logic [5:0]  LastIdx  = 6'(NUM_MEAS - 1);
  localparam logic [15:0] Offset16 = 16'(OFFSET);

  state_e             state_q, state_d;
  logic signed [16:0] acc_q [NUM_MEAS];
  logic signed [16:0] acc_d [NUM_MEAS];
  logic [5:0]         pix_cnt_q, pix_cnt_d;
  logic [5:0]         idx_q, idx_d;
  logic [15:0]        data_q, data_d;
  logic signed [16:0] pix_ext;

  assign pix_ext = $signed({9'd0, bus.pixel_in});

  // Row 0 is the plain sum; other rows are zero-mean and get the bias.
  // Truncating before the add equals truncating the 17-bit sum.
  function automatic logic [15:0] fmt(input logic [5:0] k, input logic [15:0] a);
    fmt = (k == 6'd0) ? a : a + Offset16;
  endfunction

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    idx_d     = idx_q;
    data_d    = data_q;
    for (int k = 0; k < NUM_MEAS; k++) acc_d[k] = acc_q[k];

    case (state_q)
      StAccum: begin
        if (bus.pixel_valid) begin
          // Hadamard sign: odd parity of (k AND i) means -1.
          for (int k = 0; k < NUM_MEAS; k++) begin
            if (^(6'(k) & pix_cnt_q)) acc_d[k] = acc_q[k] - pix_ext;
            else                      acc_d[k] = acc_q[k] + pix_ext;
          end
          pix_cnt_d = pix_cnt_q + 6'd1;
          if (pix_cnt_q == 6'd63) begin
            state_d = StOutput;
            idx_d   = 6'd0;
            // Preload measurement 0 including the pixel accepted this edge.
            data_d  = fmt(6'd0, acc_d[0][15:0]);
          end
        end
      end

      StOutput: begin
        if (bus.meas_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 6'd1;
            for (int k = 0; k < NUM_MEAS; k++) begin
              if (6'(k) == idx_q + 6'd1) data_d = fmt(6'(k), acc_q[k][15:0]);
            end
          end
        end
      end

      StDone: begin
        for (int k = 0; k < NUM_MEAS; k++) acc_d[k] = '0;
        pix_cnt_d = 6'd0;
        idx_d     = 6'd0;
        data_d    = 16'd0;
        state_d   = StAccum;
      end

      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StAccum;
      pix_cnt_q <= 6'd0;
      idx_q     <= 6'd0;
      data_q    <= 16'd0;
      for (int k = 0; k < NUM_MEAS; k++) acc_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      for (int k = 0; k < NUM_MEAS; k++) acc_q[k] <= acc_d[k];
    end
  end

  // All outputs depend only on registered state.
  assign bus.pixel_ready = (state_q == StAccum);
  assign bus.meas_valid  = (state_q == StOutput);
  assign bus.finish_flag = (state_q == StDone);
  assign bus.meas_last   = (state_q == StOutput) && (idx_q == LastIdx);
  assign bus.meas_data   = data_q;
  assign bus.meas_index  = idx_q;

endmodule

// File: tb/tb_frequency_measure_encoder.sv
module tb_frequency_measure_encoder;

  typedef struct {
    logic [5:0]  idx;
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [511:0] pix;
    int           k0, k1, k2;
    logic [15:0]  e0, e1, e2;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frequency_measure_encoder_if b48 ();
  frequency_measure_encoder_if b32 ();

  frequency_measure_encoder #(.NUM_MEAS(48), .OFFSET(8192)) dut48 (
    .clk   (clk),
    .reset (reset),
    .bus   (b48)
  );

  frequency_measure_encoder #(.NUM_MEAS(32), .OFFSET(8192)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (b32)
  );

  int checks = 0;
  int errors = 0;

  exp_t        q48[$];
  exp_t        q32[$];
  int          fin_stage [2];
  int          xfers [2];
  bit          rnd_bp [2];
  int          bp_left = 0;
  logic [15:0] got [2][64];
  vec_t        vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct sum of signed pixels, sign by popcount parity.
  function automatic logic [15:0] model(input logic [511:0] pix, input int k);
    int acc = 0;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] m;
      m = 6'(k) & 6'(i);
      if ($countones(m) % 2 == 1) acc -= int'(pix[8*i +: 8]);
      else                        acc += int'(pix[8*i +: 8]);
    end
    if (k == 0) return 16'(acc);
    return 16'(acc + 8192);
  endfunction

  task automatic push_block(input int w, input logic [511:0] pix);
    exp_t e;
    int nm;
    nm = (w == 0) ? 48 : 32;
    for (int k = 0; k < nm; k++) begin
      e.idx  = 6'(k);
      e.data = model(pix, k);
      e.last = (k == nm - 1);
      if (w == 0) q48.push_back(e);
      else        q32.push_back(e);
    end
  endtask

  task automatic set_pix(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin b48.pixel_valid = v; b48.pixel_in = d; end
    else        begin b32.pixel_valid = v; b32.pixel_in = d; end
  endtask

  // Drives the first n pixels of a block; the expected results are queued only
  // once pixel 63 is certain to be accepted.
  task automatic drive_block(input int w, input logic [511:0] pix, input bit gaps, input int n);
    int   i = 0;
    int   g = 0;
    logic pr;
    while (i < n && g < 3000) begin
      @(negedge clk);
      g++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        set_pix(w, 1'b0, 8'($urandom));
      end else begin
        set_pix(w, 1'b1, pix[8*i +: 8]);
        pr = (w == 0) ? b48.pixel_ready : b32.pixel_ready;
        if (pr) begin
          if (i == 63) push_block(w, pix);
          i++;
        end
      end
    end
    if (i < n) begin
      errors++;
      $display("FAIL drive_timeout: got %0d pixels accepted, expected %0d", i, n);
    end
    @(negedge clk);
    set_pix(w, 1'b0, 8'd0);
    if (n == 64) begin
      chk("first_meas_latency_valid", (w == 0) ? b48.meas_valid : b32.meas_valid, 1);
      chk("first_meas_latency_index", (w == 0) ? b48.meas_index : b32.meas_index, 0);
    end
  endtask

  task automatic wait_idle(input int w);
    int g = 0;
    while (((w == 0 ? q48.size() : q32.size()) != 0 || fin_stage[w] != 0) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) begin
      errors++;
      $display("FAIL wait_idle_timeout: got %0d pending, expected 0",
               (w == 0) ? q48.size() : q32.size());
    end
  endtask

  task automatic mon(input int w);
    logic        v, last, fin, pr, rdy;
    logic [5:0]  idx;
    logic [15:0] d;
    exp_t        e;
    bit          have;
    if (w == 0) begin
      v = b48.meas_valid; last = b48.meas_last; fin = b48.finish_flag;
      pr = b48.pixel_ready; idx = b48.meas_index; d = b48.meas_data;
    end else begin
      v = b32.meas_valid; last = b32.meas_last; fin = b32.finish_flag;
      pr = b32.pixel_ready; idx = b32.meas_index; d = b32.meas_data;
    end

    if (fin_stage[w] == 1) begin
      chk("finish_pulse", fin, 1);
      chk("done_pixel_ready", pr, 0);
      fin_stage[w] = 2;
    end else if (fin_stage[w] == 2) begin
      chk("finish_cleared", fin, 0);
      chk("ready_after_done", pr, 1);
      fin_stage[w] = 0;
    end else if (fin) begin
      errors++;
      $display("FAIL spurious_finish: got 1, expected 0 (t=%0t)", $time);
    end

    if (w == 0 && bp_left > 0 && v && idx == 6'd7) begin
      rdy = 1'b0;
      bp_left--;
      chk("bp_hold_index", idx, 7);
      chk("bp_pixel_ready", pr, 0);
      if (q48.size() > 0) chk("bp_hold_data", d, q48[0].data);
    end else begin
      rdy = rnd_bp[w] ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (w == 0) b48.meas_ready = rdy;
    else        b32.meas_ready = rdy;

    if (v && rdy) begin
      have = (w == 0) ? (q48.size() > 0) : (q32.size() > 0);
      if (!have) begin
        errors++;
        $display("FAIL unexpected_meas: got index %0d data %0d, expected no output", idx, d);
      end else begin
        e = (w == 0) ? q48.pop_front() : q32.pop_front();
        chk("meas_index", idx, e.idx);
        chk("meas_data", d, e.data);
        chk("meas_last", last, e.last);
        got[w][idx] = d;
        xfers[w]++;
        if (e.last) fin_stage[w] = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    logic [511:0] p;
    set_pix(0, 1'b0, 8'd0);
    set_pix(1, 1'b0, 8'd0);
    b48.meas_ready = 1'b0;
    b32.meas_ready = 1'b0;
    fin_stage[0] = 0; fin_stage[1] = 0;
    xfers[0] = 0; xfers[1] = 0;
    rnd_bp[0] = 1'b0; rnd_bp[1] = 1'b0;

    // Vector table: pixels plus three hand-derived spot measurements.
    vecs[0] = '{pix: '0, k0: 0, k1: 1, k2: 47, e0: 16'd0, e1: 16'd8192, e2: 16'd8192};
    vecs[1] = '{pix: '1, k0: 0, k1: 1, k2: 47, e0: 16'd16320, e1: 16'd8192, e2: 16'd8192};
    p = '0; p[7:0] = 8'd100;
    vecs[2] = '{pix: p, k0: 0, k1: 1, k2: 47, e0: 16'd100, e1: 16'd8292, e2: 16'd8292};
    p = '0; p[511:504] = 8'd10;
    vecs[3] = '{pix: p, k0: 0, k1: 3, k2: 7, e0: 16'd10, e1: 16'd8202, e2: 16'd8182};
    for (int i = 0; i < 64; i++) p[8*i +: 8] = 8'(i);
    vecs[4] = '{pix: p, k0: 1, k1: 2, k2: 32, e0: 16'd8160, e1: 16'd8128, e2: 16'd7168};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_pixel_ready", b48.pixel_ready, 1);
    chk("rst_meas_valid", b48.meas_valid, 0);
    chk("rst_meas_last", b48.meas_last, 0);
    chk("rst_finish", b48.finish_flag, 0);
    chk("rst_meas_index", b48.meas_index, 0);
    chk("rst_meas_data", b48.meas_data, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      xfers[0] = 0;
      if (v == 1) bp_left = 5;
      drive_block(0, vecs[v].pix, 1'b0, 64);
      wait_idle(0);
      chk("xfer_count", xfers[0], 48);
      chk("spot_a", got[0][vecs[v].k0], vecs[v].e0);
      chk("spot_b", got[0][vecs[v].k1], vecs[v].e1);
      chk("spot_c", got[0][vecs[v].k2], vecs[v].e2);
      if (v == 1) chk("bp_consumed", bp_left, 0);
    end

    // Mid-block reset: partial block must vanish without output.
    drive_block(0, vecs[1].pix, 1'b0, 30);
    #2 reset = 1'b0;
    #1;
    chk("midrst_pixel_ready", b48.pixel_ready, 1);
    chk("midrst_meas_valid", b48.meas_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_pixel_ready", b48.pixel_ready, 1);
    xfers[0] = 0;
    drive_block(0, '0, 1'b0, 64);
    wait_idle(0);
    chk("postrst_xfers", xfers[0], 48);
    chk("postrst_meas0", got[0][0], 0);
    chk("postrst_meas1", got[0][1], 8192);
    chk("postrst_meas47", got[0][47], 8192);

    // NUM_MEAS=32 instance: random pixels, pixel gaps and random backpressure.
    rnd_bp[1] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) p[8*i +: 8] = 8'($urandom);
      xfers[1] = 0;
      drive_block(1, p, 1'b1, 64);
      wait_idle(1);
      chk("nm32_xfers", xfers[1], 32);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
